stage_sequencer: RTL

Multi-cycle stage controller for the RV32 core. It owns the `stage` bus that `pc_control`, the register file and the ALU decode. It steps each instruction through fetch, decode, execute, optional memory access and register update. It handshakes with the memory port through a ready/wait interface, counts retired instructions, supports halting at an instruction boundary, and traps stuck bus transactions with a timeout.

---
 rtl/stage_sequencer.sv | 95 +++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle stage controller: steps each instruction through fetch, decode, execute,
// optional memory access and register update, with halt support and bus-timeout trapping.
module stage_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic [2:0]  stage,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        halted,
  output logic        bus_error,
  output logic [31:0] instret
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] RISCV_LOAD  = 7'b0000011;
  localparam logic [6:0] RISCV_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_DECODE     = 3'd1,
    ST_EXECUTE    = 3'd2,
    ST_MEMORY     = 3'd3,
    ST_REG_UPDATE = 3'd4,
    ST_HALTED     = 3'd5,
    ST_ERROR      = 3'd7
  } stage_t;

  stage_t        r_stage, w_stage_next;
  logic [CW-1:0] r_wait, w_wait_next;
  logic          r_bus_error, w_bus_error_next;
  logic [31:0]   r_instret;
  logic          w_timeout;
  logic          w_is_mem_op;

  assign w_timeout   = (TIMEOUT_CYCLES != 0) && !mem_ready && (r_wait == LIMIT);
  assign w_is_mem_op = (opcode == RISCV_LOAD) || (opcode == RISCV_STORE);

  // Wait counter defaults to zero on every transition, so any entry into a bus stage starts clean.
  always_comb begin
    w_stage_next     = r_stage;
    w_wait_next      = '0;
    w_bus_error_next = r_bus_error;
    case (r_stage)
      ST_FETCH, ST_MEMORY: begin
        if (mem_ready) begin
          w_stage_next = (r_stage == ST_FETCH) ? ST_DECODE : ST_REG_UPDATE;
        end else if (w_timeout) begin
          w_stage_next     = ST_ERROR;
          w_bus_error_next = 1'b1;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      ST_DECODE:     w_stage_next = ST_EXECUTE;
      ST_EXECUTE:    w_stage_next = w_is_mem_op ? ST_MEMORY : ST_REG_UPDATE;
      ST_REG_UPDATE: w_stage_next = halt_req ? ST_HALTED : ST_FETCH;
      ST_HALTED:     w_stage_next = halt_req ? ST_HALTED : ST_FETCH;
      ST_ERROR:      w_stage_next = ST_ERROR;
      default: begin
        w_stage_next     = ST_ERROR;
        w_bus_error_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage     <= ST_FETCH;
      r_wait      <= '0;
      r_bus_error <= 1'b0;
      r_instret   <= '0;
    end else begin
      r_stage     <= w_stage_next;
      r_wait      <= w_wait_next;
      r_bus_error <= w_bus_error_next;
      if (r_stage == ST_REG_UPDATE) r_instret <= r_instret + 32'd1;
    end
  end

  assign stage     = r_stage;
  assign mem_req   = (r_stage == ST_FETCH) || (r_stage == ST_MEMORY);
  assign mem_we    = (r_stage == ST_MEMORY) && (opcode == RISCV_STORE);
  assign ir_load   = (r_stage == ST_FETCH) && mem_ready;
  assign halted    = (r_stage == ST_HALTED);
  assign bus_error = r_bus_error;
  assign instret   = r_instret;

endmodule
